instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/proc_pkg.sv | 37 +++
 rtl/opcode_decode.sv | 29 ++
 rtl/instr_sequencer.sv | 108 ++++++++++
 tb/tb_instr_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared processor definitions: state codes, opcode values and widths used by
// the instruction sequencer and the control unit.
package proc_pkg;

   localparam int unsigned STATE_W = 6;
   localparam int unsigned OP_W    = 8;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE   = 6'd0,
      ST_FETCH1 = 6'd1,
      ST_FETCH2 = 6'd2,
      ST_FETCH3 = 6'd3,
      ST_CLAC   = 6'd4,
      ST_LDAC1  = 6'd5,
      ST_LDAC2  = 6'd6,
      ST_LDAC3  = 6'd7,
      ST_STAC1  = 6'd8,
      ST_STAC2  = 6'd9,
      ST_STAC3  = 6'd10,
      ST_MVACR  = 6'd11,
      ST_MVRAC  = 6'd12,
      ST_ADD    = 6'd13,
      ST_MUL    = 6'd14,
      ST_DECODE = 6'd15,
      ST_END    = 6'd16
   } state_t;

   localparam logic [OP_W-1:0] OP_CLAC  = 8'h01;
   localparam logic [OP_W-1:0] OP_LDAC  = 8'h02;
   localparam logic [OP_W-1:0] OP_STAC  = 8'h03;
   localparam logic [OP_W-1:0] OP_MVACR = 8'h04;
   localparam logic [OP_W-1:0] OP_MVRAC = 8'h05;
   localparam logic [OP_W-1:0] OP_ADD   = 8'h06;
   localparam logic [OP_W-1:0] OP_MUL   = 8'h07;
   localparam logic [OP_W-1:0] OP_END   = 8'hFF;

endpackage

// File: rtl/opcode_decode.sv
// Combinational opcode dispatch: maps the IR opcode to the first execute
// state, flagging any opcode that has no defined instruction.
module opcode_decode
   import proc_pkg::*;
#(
   parameter int unsigned OPW = 8
) (
   input  logic [OPW-1:0] ir_opcode,
   output state_t         next_state_c,
   output logic           illegal_c
);

   always_comb begin
      next_state_c = ST_IDLE;
      illegal_c    = 1'b0;
      case (ir_opcode)
         OPW'(OP_CLAC):  next_state_c = ST_CLAC;
         OPW'(OP_LDAC):  next_state_c = ST_LDAC1;
         OPW'(OP_STAC):  next_state_c = ST_STAC1;
         OPW'(OP_MVACR): next_state_c = ST_MVACR;
         OPW'(OP_MVRAC): next_state_c = ST_MVRAC;
         OPW'(OP_ADD):   next_state_c = ST_ADD;
         OPW'(OP_MUL):   next_state_c = ST_MUL;
         OPW'(OP_END):   next_state_c = ST_END;
         default:        illegal_c    = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: walks fetch/decode/execute states, counts retired
// instructions and flags undefined opcodes; stall freezes everything but IDLE.
module instr_sequencer
   import proc_pkg::*;
#(
   parameter int unsigned OPW  = 8,
   parameter int unsigned CNTW = 16
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               start,
   input  logic               stall,
   input  logic [OPW-1:0]     ir_opcode,
   output logic [STATE_W-1:0] state,
   output logic               busy,
   output logic               done,
   output logic               illegal,
   output logic [CNTW-1:0]    instr_count
);

   state_t            state_q;
   state_t            state_d;
   state_t            adv_state;
   state_t            dec_state;
   logic              dec_illegal;
   logic              retire;
   logic              known;
   logic              done_d;
   logic              illegal_d;
   logic [CNTW-1:0]   count_d;

   opcode_decode #(.OPW(OPW)) u_decode (
      .ir_opcode    (ir_opcode),
      .next_state_c (dec_state),
      .illegal_c    (dec_illegal)
   );

   // All sequencer state in one register block.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         done        <= 1'b0;
         illegal     <= 1'b0;
         instr_count <= '0;
      end else begin
         state_q     <= state_d;
         done        <= done_d;
         illegal     <= illegal_d;
         instr_count <= count_d;
      end
   end

   // Next state and register updates; adv_state is where an unstalled cycle goes.
   always_comb begin
      state_d   = state_q;
      done_d    = 1'b0;
      illegal_d = illegal;
      count_d   = instr_count;
      adv_state = ST_IDLE;
      retire    = 1'b0;
      known     = 1'b1;

      case (state_q)
         ST_IDLE:   adv_state = ST_FETCH1;
         ST_FETCH1: adv_state = ST_FETCH2;
         ST_FETCH2: adv_state = ST_FETCH3;
         ST_FETCH3: adv_state = ST_DECODE;
         ST_DECODE: adv_state = dec_state;
         ST_LDAC1:  adv_state = ST_LDAC2;
         ST_LDAC2:  adv_state = ST_LDAC3;
         ST_STAC1:  adv_state = ST_STAC2;
         ST_STAC2:  adv_state = ST_STAC3;
         ST_CLAC, ST_LDAC3, ST_STAC3, ST_MVACR, ST_MVRAC, ST_ADD, ST_MUL: begin
            adv_state = ST_FETCH1;
            retire    = 1'b1;
         end
         ST_END: begin
            adv_state = ST_IDLE;
            retire    = 1'b1;
         end
         default:   known = 1'b0;
      endcase

      // Unreachable codes recover to IDLE even while stalled.
      if (!known) begin
         state_d = ST_IDLE;
      end else if (state_q == ST_IDLE) begin
         if (start) begin
            state_d   = ST_FETCH1;
            illegal_d = 1'b0;
            count_d   = '0;
         end
      end else if (!stall) begin
         state_d = adv_state;
         done_d  = (state_q == ST_END);
         if ((state_q == ST_DECODE) && dec_illegal) begin
            illegal_d = 1'b1;
         end
         if (retire) begin
            count_d = instr_count + CNTW'(1);
         end
      end
   end

   assign state = state_q;
   assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized scoreboard bench for instr_sequencer: programs are expanded into
// per-cycle stimulus and expected outputs from the instruction-level rules.
module tb_instr_sequencer;

   localparam int unsigned OPW  = 8;
   localparam int unsigned CNTW = 8;
   localparam int unsigned SW   = 6;

   logic            clock     = 1'b0;
   logic            reset_n;
   logic            start     = 1'b0;
   logic            stall     = 1'b0;
   logic [OPW-1:0]  ir_opcode = '0;
   logic [SW-1:0]   state;
   logic            busy;
   logic            done;
   logic            illegal;
   logic [CNTW-1:0] instr_count;

   instr_sequencer #(.OPW(OPW), .CNTW(CNTW)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .start       (start),
      .stall       (stall),
      .ir_opcode   (ir_opcode),
      .state       (state),
      .busy        (busy),
      .done        (done),
      .illegal     (illegal),
      .instr_count (instr_count)
   );

   always #5 clock = ~clock;

   typedef struct { logic start; logic stall; logic [OPW-1:0] op; } stim_t;
   typedef struct { int st; logic dn; logic ill; logic [CNTW-1:0] cnt; } exp_t;
   typedef struct { int st; bit retire; bit set_ill; bit fin; bit is_dec; logic [OPW-1:0] op; } step_t;

   stim_t           stim_q[$];
   exp_t            exp_q[$];
   logic [OPW-1:0]  prog_q[$];
   int              n_checks = 0;
   int              n_fail   = 0;
   logic [CNTW-1:0] m_cnt    = '0;
   logic            m_ill    = 1'b0;

   function automatic logic [OPW-1:0] rnd_op();
      return OPW'($urandom_range(0, 255));
   endfunction

   function automatic logic rnd_bit();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic exp_t mk_exp(input int st, input logic dn, input logic ill, input logic [CNTW-1:0] cnt);
      exp_t e;
      e.st = st; e.dn = dn; e.ill = ill; e.cnt = cnt;
      return e;
   endfunction

   function automatic step_t mk_step(input int st, input bit ret, input bit ill, input bit fin,
                                     input bit dec, input logic [OPW-1:0] op);
      step_t s;
      s.st = st; s.retire = ret; s.set_ill = ill; s.fin = fin; s.is_dec = dec; s.op = op;
      return s;
   endfunction

   task automatic check(input string name, input exp_t e);
      n_checks++;
      if (state !== SW'(e.st) || busy !== 1'(e.st != 0) || done !== e.dn ||
          illegal !== e.ill || instr_count !== e.cnt) begin
         n_fail++;
         $display("FAIL %s @%0t: got state=%0d busy=%0b done=%0b illegal=%0b count=%0d, expected state=%0d busy=%0b done=%0b illegal=%0b count=%0d",
                  name, $time, state, busy, done, illegal, instr_count,
                  e.st, (e.st != 0), e.dn, e.ill, e.cnt);
      end
   endtask

   // One input cycle plus the outputs expected after the following edge.
   task automatic push(input logic s_start, input logic s_stall, input logic [OPW-1:0] op,
                       input int est, input logic edn);
      stim_t s;
      s.start = s_start; s.stall = s_stall; s.op = op;
      stim_q.push_back(s);
      exp_q.push_back(mk_exp(est, edn, m_ill, m_cnt));
   endtask

   // Expand prog_q into the ideal state path, then emit cycles with stalls inserted.
   task automatic run_program(input int stall_pct, input int forced_st, input int forced_n);
      step_t path[$];
      int    ex[$];
      bit    legal;
      bit    forced_used;
      int    nstall;
      forced_used = 1'b0;
      for (int i = 0; i < prog_q.size(); i++) begin
         legal = 1'b1;
         case (prog_q[i])
            8'h01:   ex = '{4};
            8'h02:   ex = '{5, 6, 7};
            8'h03:   ex = '{8, 9, 10};
            8'h04:   ex = '{11};
            8'h05:   ex = '{12};
            8'h06:   ex = '{13};
            8'h07:   ex = '{14};
            8'hFF:   ex = '{16};
            default: begin ex = '{}; legal = 1'b0; end
         endcase
         path.push_back(mk_step(1, 0, 0, 0, 0, '0));
         path.push_back(mk_step(2, 0, 0, 0, 0, '0));
         path.push_back(mk_step(3, 0, 0, 0, 0, '0));
         path.push_back(mk_step(15, 0, !legal, 0, 1, prog_q[i]));
         if (!legal) break;
         for (int j = 0; j < ex.size(); j++)
            path.push_back(mk_step(ex[j], j == ex.size() - 1, 0, ex[j] == 16, 0, '0));
         if (prog_q[i] == 8'hFF) break;
      end
      m_cnt = '0;
      m_ill = 1'b0;
      push(1'b1, rnd_bit(), rnd_op(), 1, 1'b0);
      for (int j = 0; j < path.size(); j++) begin
         nstall = 0;
         if (path[j].st == forced_st && !forced_used) begin
            nstall      = forced_n;
            forced_used = 1'b1;
         end else begin
            while (nstall < 3 && $urandom_range(0, 99) < stall_pct) nstall++;
         end
         repeat (nstall) push(rnd_bit(), 1'b1, rnd_op(), path[j].st, 1'b0);
         if (path[j].retire) m_cnt = m_cnt + CNTW'(1);
         if (path[j].set_ill) m_ill = 1'b1;
         push(rnd_bit(), 1'b0, path[j].is_dec ? path[j].op : rnd_op(),
              (j + 1 < path.size()) ? path[j + 1].st : 0, 1'(path[j].fin));
      end
      repeat ($urandom_range(1, 3)) push(1'b0, rnd_bit(), rnd_op(), 0, 1'b0);
      prog_q.delete();
   endtask

   // Wait until every queued cycle has been driven and checked.
   task automatic drain();
      int b;
      b = 0;
      do begin
         @(posedge clock);
         #2;
         b++;
      end while ((stim_q.size() != 0 || exp_q.size() != 0) && b < 5000);
      if (stim_q.size() != 0 || exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain_timeout: %0d stim and %0d expectations still queued, expected 0",
                  stim_q.size(), exp_q.size());
         stim_q.delete();
         exp_q.delete();
      end
   endtask

   always @(negedge clock) begin
      if (stim_q.size() != 0) begin
         stim_t s;
         s = stim_q.pop_front();
         start     = s.start;
         stall     = s.stall;
         ir_opcode = s.op;
      end
   end

   always @(posedge clock) begin
      #1;
      if (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check("trace", e);
      end
   end

   initial begin
      reset_n = 1'b0;
      #1;
      check("reset_state", mk_exp(0, 1'b0, 1'b0, '0));
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;

      drain();
      repeat (3) push(1'b0, rnd_bit(), rnd_op(), 0, 1'b0);

      drain(); prog_q = '{8'h01, 8'hFF};                      run_program(0, -1, 0);
      drain(); prog_q = '{8'h02, 8'hFF};                      run_program(0, -1, 0);
      drain(); prog_q = '{8'h03, 8'hFF};                      run_program(0, 9, 3);
      drain(); prog_q = '{8'h01, 8'h3C};                      run_program(0, -1, 0);
      drain(); prog_q = '{8'h04, 8'h05, 8'h06, 8'h07, 8'hFF}; run_program(30, -1, 0);

      for (int p = 0; p < 20; p++) begin
         drain();
         repeat ($urandom_range(1, 8)) prog_q.push_back(OPW'($urandom_range(1, 7)));
         if ($urandom_range(0, 4) == 0)
            prog_q.push_back(($urandom_range(0, 1) == 0) ? OPW'(0) : OPW'($urandom_range(8, 254)));
         else
            prog_q.push_back(8'hFF);
         run_program(25, -1, 0);
      end

      // Counter wrap: more retirements than the counter can hold.
      drain();
      repeat (260) prog_q.push_back(8'h01);
      prog_q.push_back(8'hFF);
      run_program(0, -1, 0);

      // Reset while stalled in LDAC2.
      drain();
      m_cnt = '0;
      m_ill = 1'b0;
      push(1'b1, 1'b0, rnd_op(), 1, 1'b0);
      push(1'b0, 1'b0, rnd_op(), 2, 1'b0);
      push(1'b0, 1'b0, rnd_op(), 3, 1'b0);
      push(1'b0, 1'b0, rnd_op(), 15, 1'b0);
      push(1'b0, 1'b0, 8'h02, 5, 1'b0);
      push(1'b0, 1'b0, rnd_op(), 6, 1'b0);
      push(1'b0, 1'b1, rnd_op(), 6, 1'b0);
      push(1'b0, 1'b1, rnd_op(), 6, 1'b0);
      drain();
      #1;
      reset_n = 1'b0;
      #1;
      check("async_reset", mk_exp(0, 1'b0, 1'b0, '0));
      @(posedge clock);
      #1;
      check("reset_held", mk_exp(0, 1'b0, 1'b0, '0));
      @(negedge clock);
      reset_n = 1'b1;
      m_cnt = '0;
      m_ill = 1'b0;
      drain();
      repeat (3) push(1'b0, rnd_bit(), rnd_op(), 0, 1'b0);
      drain(); prog_q = '{8'h06, 8'hFF}; run_program(20, -1, 0);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
